// File: rtl/burst_data_mem.sv
// Word-addressed data memory built from four byte lanes, serving single
// byte/half/word accesses and word bursts of up to MAX_BEATS beats.
module burst_data_mem #(
  parameter int DEPTH     = 1024,
  parameter int MAX_BEATS = 8,
  localparam int CW       = $clog2(MAX_BEATS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [CW-1:0] req_count,
  input  logic          beat_wvalid,
  input  logic [31:0]   beat_wdata,
  output logic          beat_wready,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_last,
  output logic          rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] len;
  logic [AW-1:0] base;

  logic [7:0]    lanes [4][DEPTH];

  logic [AW-1:0] req_idx;
  logic [1:0]    off;
  logic          accept;
  logic          req_err;
  logic          is_burst;
  logic [AW-1:0] burst_idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_burst;
  logic [31:0]   load_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [3:0]    we;
  logic [AW-1:0] widx;
  logic [31:0]   wword;
  logic          unused_addr;

  assign req_idx     = req_addr[AW+1:2];
  assign off         = req_addr[1:0];
  assign accept      = req_valid & req_ready;
  assign is_burst    = req_count >= CW'(2);
  assign burst_idx   = base + AW'(cnt);
  assign unused_addr = ^req_addr[31:AW+2];

  assign rd_word  = {lanes[3][req_idx], lanes[2][req_idx],
                     lanes[1][req_idx], lanes[0][req_idx]};
  assign rd_burst = {lanes[3][burst_idx], lanes[2][burst_idx],
                     lanes[1][burst_idx], lanes[0][burst_idx]};

  always_comb begin
    req_err = (req_size == 2'd3)
            | ((req_size == 2'd1) & off[0])
            | ((req_size == 2'd2) & (off != 2'd0))
            | (req_count > CW'(MAX_BEATS))
            | (is_burst & (req_size != 2'd2));
  end

  always_comb begin
    ld_byte   = rd_word[{off, 3'b000} +: 8];
    ld_half   = off[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (req_size)
      2'd0:    load_data = {{24{req_signed & ld_byte[7]}}, ld_byte};
      2'd1:    load_data = {{16{req_signed & ld_half[15]}}, ld_half};
      default: load_data = rd_word;
    endcase
  end

  // Single stores replicate the data across lanes so the enables alone pick the target bytes.
  always_comb begin
    we    = '0;
    widx  = req_idx;
    wword = req_wdata;
    if (state == WBURST) begin
      if (beat_wvalid) begin
        we    = '1;
        widx  = burst_idx;
        wword = beat_wdata;
      end
    end else if (state == IDLE && accept && req_write && !req_err) begin
      case (req_size)
        2'd0: begin
          we    = 4'b0001 << off;
          wword = {4{req_wdata[7:0]}};
        end
        2'd1: begin
          we    = off[1] ? 4'b1100 : 4'b0011;
          wword = {2{req_wdata[15:0]}};
        end
        default: we = '1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (we[k]) lanes[k][widx] <= wword[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      len         <= '0;
      base        <= '0;
      req_ready   <= 1'b0;
      beat_wready <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_last    <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            if (req_err) begin
              rsp_valid <= 1'b1;
              rsp_last  <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (!is_burst) begin
              rsp_valid <= 1'b1;
              rsp_last  <= 1'b1;
              rsp_rdata <= req_write ? '0 : load_data;
            end else begin
              req_ready <= 1'b0;
              cnt       <= CW'(1);
              len       <= req_count;
              base      <= req_idx;
              if (req_write) begin
                state       <= WBURST;
                beat_wready <= 1'b1;
              end else begin
                state     <= RBURST;
                rsp_valid <= 1'b1;
                rsp_rdata <= rd_word;
              end
            end
          end
        end
        RBURST: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= rd_burst;
          if (cnt == len - CW'(1)) begin
            rsp_last  <= 1'b1;
            state     <= IDLE;
            req_ready <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WBURST: begin
          if (beat_wvalid) begin
            if (cnt == len - CW'(1)) begin
              state       <= IDLE;
              beat_wready <= 1'b0;
              req_ready   <= 1'b1;
              rsp_valid   <= 1'b1;
              rsp_last    <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/burst_data_mem.md
BURST_DATA_MEM -- requirements
Module: burst_data_mem

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 1024, giving the number of 32-bit words; it is a power of 2 and at least 4.
REQ-002 The block SHALL have a parameter MAX_BEATS, default 8, giving the maximum burst length in words; it is at least 2.
REQ-003 The block SHALL have the derived width CW = $clog2(MAX_BEATS)+1.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  — rising-edge clock.
REQ-006 rst_n  in  1  — asynchronous active-low reset.
REQ-007 req_valid  in  1  — command present.
REQ-008 req_ready  out  1  — command accepted when high with req_valid.
REQ-009 req_write  in  1  — 1 = store, 0 = load.
REQ-010 req_size  in  2  — 0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-011 req_signed  in  1  — sign-extend load data (byte/half only).
REQ-012 req_addr  in  32  — byte address.
REQ-013 req_wdata  in  32  — store data (single store, or beat 0 of a burst store).
REQ-014 req_count  in  CW  — beat count; 0 and 1 both mean a single access.
REQ-015 beat_wvalid  in  1  — burst-store data for beats 1..C-1 is present.
REQ-016 beat_wdata  in  32  — burst-store beat data.
REQ-017 beat_wready  out  1  — burst-store beat accepted when high with beat_wvalid.
REQ-018 rsp_valid  out  1  — response beat; there is no backpressure.
REQ-019 rsp_rdata  out  32  — load data, right-justified; 0 for stores and errors.
REQ-020 rsp_last  out  1  — final response of the command.
REQ-021 rsp_err  out  1  — command rejected; no memory state changed.

Function
REQ-022 The block SHALL hold DEPTH words as four byte lanes; lane k holds byte addresses with addr[1:0] = k.
REQ-023 Word index SHALL be addr[$clog2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-024 The FSM SHALL have three states: IDLE, RBURST, WBURST.
REQ-025 req_ready SHALL be 1 only in IDLE.
REQ-026 Single access: a command accepted in cycle N (count ≤ 1) SHALL produce rsp_valid = 1 and rsp_last = 1 in cycle N+1, and the FSM stays in IDLE.
REQ-027 Single store byte enables:
  - byte: lane addr[1:0] only, data taken from req_wdata[7:0];
  - half: lanes {addr[1],0} and {addr[1],1}, data from req_wdata[15:0];
  - word: all four lanes;
  - all other lanes unchanged.
REQ-028 Single load: the selected lane(s) SHALL be returned right-justified in rsp_rdata; upper bits are zero, or copies of the top returned bit when req_signed = 1 and size ≠ word.
REQ-029 Error: size = 3, half with addr[0] = 1, word with addr[1:0] ≠ 0, count > MAX_BEATS, or count ≥ 2 with size ≠ word SHALL give a single response in cycle N+1 with rsp_valid = 1, rsp_err = 1, rsp_last = 1, rsp_rdata = 0, no write, and the FSM stays in IDLE.
REQ-030 Burst load (count C ≥ 2, legal): IDLE→RBURST; beats i = 0..C-1 read word (index+i) mod DEPTH; rsp_valid in cycles N+1..N+C consecutively; rsp_last only on beat C-1; return to IDLE so req_ready = 1 in cycle N+C.
REQ-031 Burst store (count C ≥ 2, legal): beat 0 SHALL be written from req_wdata in cycle N, then IDLE→WBURST.
REQ-032 In WBURST, beat_wready SHALL be 1, and each beat_wvalid handshake writes the next word (index+i) mod DEPTH.
REQ-033 Cycles without beat_wvalid in WBURST SHALL be stalls with no write.
REQ-034 After the handshake of beat C-1, the block SHALL return to IDLE and give a single response (rsp_valid = 1, rsp_last = 1, rsp_rdata = 0) the next cycle.
REQ-035 beat_wready SHALL be 0 outside WBURST.
REQ-036 A burst SHALL wrap from word DEPTH-1 to word 0 with no error.
REQ-037 Memory read latency SHALL be exactly one cycle (synchronous read).
REQ-038 Outputs SHALL be registered.
REQ-039 A new command SHALL be accepted in the same cycle a previous response is driven, provided the block is in IDLE.
REQ-040 The beat counter SHALL count 0..C-1 with CW bits and SHALL never overflow, because C ≤ MAX_BEATS is checked at acceptance.

Reset
REQ-041 While rst_n = 0, the FSM SHALL be IDLE, the beat counter 0, req_ready = 0, and beat_wready, rsp_valid, rsp_last, rsp_err and rsp_rdata all 0.
REQ-042 req_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-043 Memory contents SHALL NOT be reset.
REQ-044 Reset mid-burst SHALL abort the burst: no further writes, no pending responses; beats already written stay written.

Verification
REQ-045 Store word 0x8899AABB to 0x10, then load byte signed at 0x11 → rsp_rdata = 0xFFFFFFAA; load half unsigned at 0x12 → 0x00008899.
REQ-046 Store half at 0x03 → rsp_err = 1 and rsp_last = 1 in cycle N+1, memory unchanged; req_size = 3 → same error response.
REQ-047 Burst store C = 4 at word DEPTH-2, with beat_wvalid deasserted one cycle mid-burst → words DEPTH-2, DEPTH-1, 0, 1 written; single ack; burst load C = 4 then returns 4 beats in consecutive cycles, rsp_last on the 4th only.
REQ-048 req_count = MAX_BEATS+1 → error response, no write; req_count = 2 with size = byte → error response.
REQ-049 rst_n pulsed low after beat 1 of a C = 4 burst store → outputs 0, IDLE; readback shows beats 0..1 written and beats 2..3 old data.
REQ-050 Back-to-back single loads → req_ready stays high and rsp_valid is high in every cycle after the first.
